// File: rtl/vid_out_conditioner.sv
// Video output stage: pixel enable, sync-derived blanking, colour expansion/tint, timing lock.
// Latency: one pixel enable from r/g/b/hs/vs_in to every registered output.
// Backpressure: none; free-running raster, outputs update only on ce_pix edges.
//
// Ports:
//   clk_sys, reset             system clock, async active-high reset
//   mode                       tint select (0 colour, 1 green, 2 amber, 3 white), latched per frame
//   r_in/g_in/b_in             core colour, IN_W bits per channel
//   hs_in/vs_in                raw core syncs, polarity set by HS_POL/VS_POL
//   ce_pix                     pixel enable, one clk_sys cycle in every CE_DIV
//   r_out/g_out/b_out          expanded, tinted, blank-gated colour (OUT_W bits)
//   hs_out/vs_out              active-high syncs
//   hblank/vblank/de           blanking derived from sync-relative counters
//   h_total/v_total            measured pixels per line / lines per frame
//   locked                     line and frame totals stable
module vid_out_conditioner #(
    parameter int IN_W     = 4,
    parameter int OUT_W    = 8,
    parameter int CE_DIV   = 4,
    parameter int CNT_W    = 12,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int H_START  = 48,
    parameter int H_ACTIVE = 640,
    parameter int V_START  = 16,
    parameter int V_ACTIVE = 200
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic [IN_W-1:0]  r_in,
    input  logic [IN_W-1:0]  g_in,
    input  logic [IN_W-1:0]  b_in,
    input  logic             hs_in,
    input  logic             vs_in,
    output logic             ce_pix,
    output logic [OUT_W-1:0] r_out,
    output logic [OUT_W-1:0] g_out,
    output logic [OUT_W-1:0] b_out,
    output logic             hs_out,
    output logic             vs_out,
    output logic             hblank,
    output logic             vblank,
    output logic             de,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] v_total,
    output logic             locked
);

    localparam int               DIV_W    = $clog2(CE_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic             HS_LVL   = (HS_POL != 0);
    localparam logic             VS_LVL   = (VS_POL != 0);
    // One extra bit so a window end of exactly 2^CNT_W is still representable.
    localparam logic [CNT_W:0]   H_LO     = (CNT_W+1)'(H_START);
    localparam logic [CNT_W:0]   H_HI     = (CNT_W+1)'(H_START + H_ACTIVE);
    localparam logic [CNT_W:0]   V_LO     = (CNT_W+1)'(V_START);
    localparam logic [CNT_W:0]   V_HI     = (CNT_W+1)'(V_START + V_ACTIVE);

    // ------------------------------------------------------------------
    // Pixel clock enable
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign ce_pix = (div_cnt == DIV_LAST);

    // ------------------------------------------------------------------
    // Sync normalisation, edges and raster counters
    // ------------------------------------------------------------------
    logic             hs_act, vs_act, hs_prev, vs_prev, hs_edge, vs_edge;
    logic [CNT_W-1:0] hcnt, vcnt, h_inc, v_inc, hc_eff, vc_eff;
    logic             vpend, v_cap;

    assign hs_act  = hs_in ^ ~HS_LVL;
    assign vs_act  = vs_in ^ ~VS_LVL;
    assign hs_edge = hs_act & ~hs_prev;
    assign vs_edge = vs_act & ~vs_prev;

    // Saturating increments double as the captured line/frame lengths.
    assign h_inc = (hcnt == CNT_MAX) ? CNT_MAX : hcnt + CNT_W'(1);
    assign v_inc = (vcnt == CNT_MAX) ? CNT_MAX : vcnt + CNT_W'(1);

    // A vsync seen anywhere in a line is held in vpend until the next hsync,
    // so the frame always restarts on a line boundary.
    assign v_cap  = hs_edge & (vpend | vs_edge);
    assign hc_eff = hs_edge ? '0 : h_inc;
    assign vc_eff = hs_edge ? (v_cap ? '0 : v_inc) : vcnt;

    // ------------------------------------------------------------------
    // Blanking window
    // ------------------------------------------------------------------
    logic h_act_n, v_act_n, de_n;

    assign h_act_n = ({1'b0, hc_eff} >= H_LO) && ({1'b0, hc_eff} < H_HI);
    assign v_act_n = ({1'b0, vc_eff} >= V_LO) && ({1'b0, vc_eff} < V_HI);
    assign de_n    = h_act_n & v_act_n;

    // ------------------------------------------------------------------
    // Colour expansion and tint
    // ------------------------------------------------------------------
    // Replicates the input MSB-first to fill the wider output.
    function automatic logic [OUT_W-1:0] expand(input logic [IN_W-1:0] c);
        logic [OUT_W-1:0] e;
        e = '0;
        for (int i = 0; i < OUT_W; i++) begin
            e[i] = c[IN_W-1-((OUT_W-1-i) % IN_W)];
        end
        return e;
    endfunction

    logic [OUT_W-1:0] r_x, g_x, b_x, y_lum, amber_g;
    logic [OUT_W+1:0] y_sum;
    logic [1:0]       mode_q;
    logic [OUT_W-1:0] r_t, g_t, b_t;

    assign r_x     = expand(r_in);
    assign g_x     = expand(g_in);
    assign b_x     = expand(b_in);
    assign y_sum   = {2'b00, r_x} + {1'b0, g_x, 1'b0} + {2'b00, b_x};
    assign y_lum   = y_sum[OUT_W+1:2];
    assign amber_g = (y_lum >> 1) + (y_lum >> 2);

    always_comb begin
        r_t = r_x;
        g_t = g_x;
        b_t = b_x;
        case (mode_q)
            2'd1: begin
                r_t = '0;
                g_t = y_lum;
                b_t = '0;
            end
            2'd2: begin
                r_t = y_lum;
                g_t = amber_g;
                b_t = '0;
            end
            2'd3: begin
                r_t = y_lum;
                g_t = y_lum;
                b_t = y_lum;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Lock tracking: each flag records whether its latest capture repeated
    // the previous one; a saturated count is never a valid measurement.
    // ------------------------------------------------------------------
    logic h_match, v_match, h_match_n, v_match_n;

    assign h_match_n = hs_edge ? ((h_inc == h_total) && (hcnt != CNT_MAX)) : h_match;
    assign v_match_n = v_cap   ? ((v_inc == v_total) && (vcnt != CNT_MAX)) : v_match;

    // ------------------------------------------------------------------
    // Per-pixel state
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
            hcnt    <= '0;
            vcnt    <= '0;
            vpend   <= 1'b0;
            mode_q  <= 2'd0;
            h_total <= '0;
            v_total <= '0;
            h_match <= 1'b0;
            v_match <= 1'b0;
            locked  <= 1'b0;
            hs_out  <= 1'b0;
            vs_out  <= 1'b0;
            hblank  <= 1'b1;
            vblank  <= 1'b1;
            de      <= 1'b0;
            r_out   <= '0;
            g_out   <= '0;
            b_out   <= '0;
        end else if (ce_pix) begin
            hs_prev <= hs_act;
            vs_prev <= vs_act;
            hcnt    <= hc_eff;
            vcnt    <= vc_eff;
            if (hs_edge) begin
                vpend   <= 1'b0;
                h_total <= h_inc;
            end else if (vs_edge) begin
                vpend <= 1'b1;
            end
            if (v_cap) begin
                v_total <= v_inc;
            end
            // Tint changes only at frame start so a line is never split.
            if (vs_edge) begin
                mode_q <= mode;
            end
            h_match <= h_match_n;
            v_match <= v_match_n;
            locked  <= h_match_n & v_match_n & (hc_eff != CNT_MAX) & (vc_eff != CNT_MAX);
            hs_out  <= hs_act;
            vs_out  <= vs_act;
            hblank  <= ~h_act_n;
            vblank  <= ~v_act_n;
            de      <= de_n;
            r_out   <= de_n ? r_t : '0;
            g_out   <= de_n ? g_t : '0;
            b_out   <= de_n ? b_t : '0;
        end
    end

endmodule

// File: tb/tb_vid_out_conditioner.sv
// Bench for vid_out_conditioner: directed raster with hand-computed expectations.
// Each pixel is driven while ce_pix is high and outputs are sampled 1 ns after that edge.
// No backpressure exists; waits on ce_pix are bounded and a timeout counts as a failure.
module tb_vid_out_conditioner;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic [1:0]  mode    = 2'd0;
    logic [3:0]  r_in    = 4'h0;
    logic [3:0]  g_in    = 4'h0;
    logic [3:0]  b_in    = 4'h0;
    logic        hs_in   = 1'b1;
    logic        vs_in   = 1'b1;
    logic        ce_pix;
    logic [7:0]  r_out, g_out, b_out;
    logic        hs_out, vs_out, hblank, vblank, de, locked;
    logic [11:0] h_total, v_total;

    int total = 0;
    int bad   = 0;

    always #5 clk_sys = ~clk_sys;

    vid_out_conditioner #(
        .IN_W(4), .OUT_W(8), .CE_DIV(4), .CNT_W(12), .HS_POL(0), .VS_POL(0),
        .H_START(48), .H_ACTIVE(640), .V_START(16), .V_ACTIVE(200)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .mode(mode),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .hs_in(hs_in), .vs_in(vs_in),
        .ce_pix(ce_pix), .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .hs_out(hs_out), .vs_out(vs_out), .hblank(hblank), .vblank(vblank), .de(de),
        .h_total(h_total), .v_total(v_total), .locked(locked)
    );

    // Drive one pixel: wait for the enable, present syncs, step past the ce edge.
    task automatic px(input logic hs, input logic vs);
        int n;
        n = 0;
        @(negedge clk_sys);
        while (ce_pix !== 1'b1 && n < 16) begin
            @(negedge clk_sys);
            n++;
        end
        if (ce_pix !== 1'b1) begin
            total++; bad++;
            $display("FAIL ce_wait_timeout ce_pix=%b required=1", ce_pix);
        end
        hs_in = hs;
        vs_in = vs;
        @(posedge clk_sys);
        #1;
    endtask

    // Active-low syncs: hsync 96 px on long lines, 2 px on short ones; vsync lines 0..2.
    task automatic send_line(input int len, input int ln, input bit early_vs);
        for (int p = 0; p < len; p++) begin
            px(!(p < ((len >= 200) ? 96 : 2)), !(ln < 3 || (early_vs && p >= 4)));
        end
    endtask

    task automatic test_reset();
        r_in = 4'hF; g_in = 4'hF; b_in = 4'hF;
        reset = 1'b1;
        repeat (3) @(negedge clk_sys);
        total++;
        if ({hblank, vblank, de, hs_out, vs_out, locked, ce_pix} !== 7'b1100000)
            begin bad++; $display("FAIL reset_flags got=%b want=1100000", {hblank, vblank, de, hs_out, vs_out, locked, ce_pix}); end
        total++;
        if ({r_out, g_out, b_out} !== 24'h0)
            begin bad++; $display("FAIL reset_rgb got=%h want=000000", {r_out, g_out, b_out}); end
        total++;
        if ({h_total, v_total} !== 24'h0)
            begin bad++; $display("FAIL reset_totals got=%h want=000000", {h_total, v_total}); end
        reset = 1'b0;
        // Checked just before edge n: the enable must be high for edges 4, 8, 12.
        for (int n = 1; n <= 12; n++) begin
            total++;
            if (ce_pix !== ((n % 4) == 0))
                begin bad++; $display("FAIL ce_pulse edge=%0d got=%b want=%b", n, ce_pix, (n % 4) == 0); end
            @(negedge clk_sys);
        end
        total++;
        if ({hblank, vblank, de, r_out, g_out, b_out} !== {3'b110, 24'h0})
            begin bad++; $display("FAIL idle_blank got=%b/%h want=110/000000", {hblank, vblank, de}, {r_out, g_out, b_out}); end
    endtask

    task automatic test_frames();
        for (int fr = 0; fr < 2; fr++) begin
            for (int ln = 0; ln < 262; ln++) begin
                send_line(8, ln, 1'b0);
                if (fr == 1) begin
                    total++;
                    if (vblank !== !(ln >= 16 && ln < 216))
                        begin bad++; $display("FAIL vblank_line ln=%0d got=%b want=%b", ln, vblank, !(ln >= 16 && ln < 216)); end
                end
            end
        end
        total++;
        if (v_total !== 12'd262) begin bad++; $display("FAIL v_total_b got=%0d want=262", v_total); end
        total++;
        if (h_total !== 12'd8) begin bad++; $display("FAIL h_total_short got=%0d want=8", h_total); end
        total++;
        if (locked !== 1'b0) begin bad++; $display("FAIL lock_before_second got=%b want=0", locked); end
    endtask

    task automatic test_hline();
        logic [26:0] got, want;
        bit          de_e;
        for (int ln = 0; ln < 100; ln++) begin
            send_line(8, ln, 1'b0);
            if (ln == 0) begin
                total++;
                if ({locked, v_total} !== {1'b1, 12'd262})
                    begin bad++; $display("FAIL lock_frame got=%b/%0d want=1/262", locked, v_total); end
            end
        end
        r_in = 4'hA; g_in = 4'h5; b_in = 4'hF;
        // Line 100: mode port moves to mono green mid-line; it must not apply yet.
        for (int p = 0; p < 800; p++) begin
            if (p == 300) mode = 2'd1;
            px(!(p < 96), 1'b1);
        end
        for (int p = 0; p < 800; p++) begin
            px(!(p < 96), 1'b1);
            de_e = (p >= 48 && p < 688);
            got  = {de, hblank, hs_out, r_out, g_out, b_out};
            want = {de_e, !de_e, (p < 96), (de_e ? 24'hAA55FF : 24'h0)};
            total++;
            if (got !== want) begin bad++; $display("FAIL pixel_101 p=%0d got=%h want=%h", p, got, want); end
            if (p == 0) begin
                total++;
                if ({locked, h_total} !== {1'b0, 12'd800})
                    begin bad++; $display("FAIL lock_drop_800 got=%b/%0d want=0/800", locked, h_total); end
            end
        end
        send_line(799, 102, 1'b0);
        total++;
        if ({locked, h_total} !== {1'b1, 12'd800}) begin bad++; $display("FAIL relock_800 got=%b/%0d want=1/800", locked, h_total); end
        send_line(800, 103, 1'b0);
        total++;
        if ({locked, h_total} !== {1'b0, 12'd799}) begin bad++; $display("FAIL short_799 got=%b/%0d want=0/799", locked, h_total); end
        send_line(800, 104, 1'b0);
        total++;
        if ({locked, h_total} !== {1'b0, 12'd800}) begin bad++; $display("FAIL after_799 got=%b/%0d want=0/800", locked, h_total); end
        send_line(8, 105, 1'b0);
        total++;
        if ({locked, h_total} !== {1'b1, 12'd800}) begin bad++; $display("FAIL relock_two got=%b/%0d want=1/800", locked, h_total); end
        for (int ln = 106; ln < 262; ln++) send_line(8, ln, 1'b0);
    endtask

    task automatic test_mode();
        // Frame D: mono green active from its first line.
        for (int ln = 0; ln < 100; ln++) send_line(8, ln, 1'b0);
        for (int p = 0; p < 60; p++) begin
            if (p < 51) begin r_in = 4'hF; g_in = 4'hF; b_in = 4'hF; end
            else        begin r_in = 4'hA; g_in = 4'h5; b_in = 4'hF; end
            if (p == 53) mode = 2'd2;
            px(!(p < 2), 1'b1);
            if (p == 50) begin
                total++;
                if ({r_out, g_out, b_out} !== 24'h00FF00) begin bad++; $display("FAIL green_white got=%h want=00ff00", {r_out, g_out, b_out}); end
            end
            if (p == 51 || p == 55) begin
                total++;
                if ({r_out, g_out, b_out} !== 24'h009400) begin bad++; $display("FAIL green_a5f p=%0d got=%h want=009400", p, {r_out, g_out, b_out}); end
            end
        end
        for (int ln = 101; ln < 262; ln++) send_line(8, ln, 1'b0);
        // Frame E: amber.
        for (int ln = 0; ln < 100; ln++) send_line(8, ln, 1'b0);
        for (int p = 0; p < 60; p++) begin
            if (p == 40) mode = 2'd3;
            px(!(p < 2), 1'b1);
            if (p == 10) begin
                total++;
                if ({r_out, g_out, b_out} !== 24'h0) begin bad++; $display("FAIL amber_blank got=%h want=000000", {r_out, g_out, b_out}); end
            end
            if (p == 50) begin
                total++;
                if ({r_out, g_out, b_out} !== 24'h946F00) begin bad++; $display("FAIL amber got=%h want=946f00", {r_out, g_out, b_out}); end
            end
        end
        for (int ln = 101; ln < 261; ln++) send_line(8, ln, 1'b0);
        // Vsync asserts mid-way through the last line; the next hsync begins the frame.
        send_line(8, 261, 1'b1);
    endtask

    task automatic test_late_vsync();
        for (int ln = 0; ln < 16; ln++) begin
            send_line(8, ln, 1'b0);
            if (ln == 0) begin
                total++;
                if (v_total !== 12'd262) begin bad++; $display("FAIL v_total_late got=%0d want=262", v_total); end
            end
        end
        total++;
        if (vblank !== 1'b1) begin bad++; $display("FAIL late_line15 vblank got=%b want=1", vblank); end
        for (int p = 0; p < 60; p++) begin
            px(!(p < 2), 1'b1);
            if (p == 50) begin
                total++;
                if ({vblank, de, r_out, g_out, b_out} !== {2'b01, 24'h949494})
                    begin bad++; $display("FAIL late_line16_white got=%b/%h want=01/949494", {vblank, de}, {r_out, g_out, b_out}); end
            end
        end
    endtask

    task automatic test_reset_midframe();
        // Vsync edge mid-line leaves a pending frame start, then reset hits.
        for (int p = 0; p < 10; p++) px(!(p < 2), !(p >= 4));
        @(negedge clk_sys);
        reset = 1'b1;
        hs_in = 1'b1;
        vs_in = 1'b1;
        #1;
        total++;
        if ({hblank, vblank, de, locked, h_total, v_total, r_out} !== {4'b1100, 24'h0, 8'h0})
            begin bad++; $display("FAIL midframe_reset got=%b/%h/%h/%h want=1100/000/000/00", {hblank, vblank, de, locked}, h_total, v_total, r_out); end
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        for (int p = 0; p < 60; p++) begin
            px(!(p < 2), 1'b1);
            if (p == 47 || p == 48) begin
                total++;
                if ({hblank, vblank} !== {(p == 47), 1'b1})
                    begin bad++; $display("FAIL post_reset_h p=%0d got=%b want=%b1", p, {hblank, vblank}, (p == 47)); end
            end
        end
        px(1'b0, 1'b1);
        total++;
        if ({h_total, v_total} !== {12'd60, 12'd0})
            begin bad++; $display("FAIL post_reset_totals got=%0d/%0d want=60/0", h_total, v_total); end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_hline();
        test_mode();
        test_late_vsync();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vid_out_conditioner.md
Name: vid_out_conditioner

Overview:
- Parametrised video output stage between the machine core and the emu-level VGA_* / CE_PIXEL ports.
- Generates the pixel clock enable and registers the core's narrow RGB and raw syncs on it.
- Derives HBlank/VBlank/DE by counting from sync edges; expands colour depth and applies frame-synchronous colour/monochrome tint modes.
- Measures line/frame totals and reports timing lock.

Parameters:
- IN_W, 4, core colour width per channel.
- OUT_W, 8, output colour width per channel; IN_W <= OUT_W <= 2*IN_W.
- CE_DIV, 4, clk_sys cycles per pixel, >= 2.
- CNT_W, 12, width of horizontal and vertical counters.
- HS_POL, 0, active level of hs_in (0 = active-low).
- VS_POL, 0, active level of vs_in.
- H_START, 48, first active pixel index after the hsync leading edge.
- H_ACTIVE, 640, active pixels per line.
- V_START, 16, first active line index after a vsync leading edge.
- V_ACTIVE, 200, active lines per frame.

Ports:
- clk_sys  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- mode  in  2  tint: 0 colour, 1 mono green, 2 mono amber, 3 mono white.
- r_in, g_in, b_in  in  IN_W each  core colour.
- hs_in, vs_in  in  1  raw core syncs, polarity per HS_POL/VS_POL.
- ce_pix  out  1  pixel enable, one clk_sys cycle in every CE_DIV.
- r_out, g_out, b_out  out  OUT_W each  conditioned colour.
- hs_out, vs_out  out  1  syncs normalised to active-high.
- hblank, vblank, de  out  1  blanking; de = ~(hblank | vblank).
- h_total  out  CNT_W  pixels in the last complete line.
- v_total  out  CNT_W  lines in the last complete frame.
- locked  out  1  timing stable.

Behaviour:
- Reset: all outputs 0 except hblank=1 and vblank=1. Divider, counters and the pending flag clear; active mode = 0.
- Divider: counts 0..CE_DIV-1. ce_pix=1 while count==CE_DIV-1, so the first pulse occurs CE_DIV cycles after reset release.
- All state below updates only on clk_sys edges with ce_pix=1. Outputs hold between enables and change on the ce edge.
- Normalisation: hs_act = hs_in ^ ~HS_POL; vs_act = vs_in ^ ~VS_POL.
- Edge detection: hs_edge = hs_act & ~hs_prev; vs_edge = vs_act & ~vs_prev. hs_prev and vs_prev are sampled every ce.
- Horizontal count: hc_eff = hs_edge ? 0 : sat(hcnt+1), saturating at 2^CNT_W-1; hcnt <= hc_eff.
  - On hs_edge, h_total <= hcnt+1 (saturating).
  - The pixel coincident with the sync edge has index 0.
- Vertical count: vs_edge sets vpend.
  - On hs_edge: vc_eff = (vpend | vs_edge) ? 0 : sat(vcnt+1); vcnt <= vc_eff; vpend clears.
  - Without hs_edge: vc_eff = vcnt.
  - When vc_eff==0 on an hs_edge, v_total <= vcnt+1 (saturating).
  - Simultaneous hs_edge and vs_edge: that line is line 0.
- Blanking:
  - hblank <= ~(H_START <= hc_eff < H_START+H_ACTIVE).
  - vblank <= ~(V_START <= vc_eff < V_START+V_ACTIVE).
  - de <= both active.
- Syncs: hs_out and vs_out are registered, so they share the single-ce latency of the colour and blanking outputs.
- Colour expansion: out bit i = in[IN_W-1 - ((OUT_W-1-i) mod IN_W)]. Examples: 4->8, 0xA -> 0xAA, 0x3 -> 0x33.
- Luma: Y = (R + 2G + B) >> 2 on expanded values, computed at OUT_W+2 bits and truncated to OUT_W.
- Tint output:
  - mode 0: R,G,B.
  - mode 1: (0, Y, 0).
  - mode 2: (Y, (Y>>1)+(Y>>2), 0).
  - mode 3: (Y, Y, Y).
- Blanked pixels: colour outputs forced to 0 whenever the registered de is 0.
- Mode latch: the active mode reloads from the mode port only on a vs_edge ce. Mid-frame changes take effect from the next frame and never mid-line.
- Lock:
  - locked <= 1 when two consecutive h_total captures are equal and the two most recent v_total captures are equal.
  - Any differing capture clears it on that same ce.
  - Saturated counters never assert locked.
- Missing sync: hcnt/vcnt saturate and hold. Outputs stay blanked because saturation lies outside the window.
- Reset mid-frame: immediate return to reset values. The first post-reset hs_edge starts at index 0 with no stale pending state.

Test Plan:
- Reset then idle, CE_DIV=4 → ce_pix pulses at cycles 4, 8, 12 after release; hblank=vblank=1; all colour outputs 0.
- 800-pixel lines, hs active-low for 96 pixels, rgb_in=0xA/0x5/0xF → de high for pixel indices 48..687 only; r/g/b_out=0xAA/0x55/0xFF; h_total=800.
- 262-line frames with V_ACTIVE=200 → vblank low for lines 16..215; v_total=262; locked=1 after the second identical frame.
- Switch mode 0→1 mid-line 100 → output unchanged until the next vs_edge, then g_out=Y, r_out=b_out=0. For R=G=B=0xF: Y=0xFF.
- hs_edge and vs_edge coincident on the same ce → that line counts as line 0; no extra line inserted; v_total unchanged from the previous frame.
- Shorten one line to 799 pixels → h_total=799 and locked drops on that ce; locked re-asserts after two consecutive 800-pixel lines.
